// File: rtl/hub_fp_pkg.sv
// Shared constants, S1 payload layout and shift clamp for the HUB normalization pipe.
package hub_fp_pkg;

  localparam int M_W  = 24;
  localparam int E_W  = 8;
  localparam int SW_W = $clog2(M_W + 1);

  typedef struct packed {
    logic [M_W:0]      mant;
    logic [SW_W-1:0]   sh;
    logic [E_W-1:0]    exp;
    logic              sign;
    logic              zero;
  } s1_payload_t;

  function automatic logic [SW_W-1:0] clamp_shift(input logic [SW_W-1:0] s);
    return (s > SW_W'(M_W)) ? SW_W'(M_W) : s;
  endfunction

endpackage

// File: rtl/hub_lshift.sv
// Combinational left barrel shifter, one mux stage per bit of the shift amount.
module hub_lshift #(
  parameter int W  = 25,
  parameter int SW = 5
) (
  input  logic [W-1:0]  data,
  input  logic [SW-1:0] sh,
  output logic [W-1:0]  result
);

  logic [W-1:0] stage [SW+1];

  assign stage[0] = data;

  for (genvar i = 0; i < SW; i++) begin : g_stage
    assign stage[i+1] = sh[i] ? (stage[i] << (2 ** i)) : stage[i];
  end

  assign result = stage[SW];

endmodule

// File: rtl/hub_norm_pipe.sv
// Two-stage elastic normalizer after the HUB adder's LZA: shift, fix LZA under-count, adjust exponent.
// Optional macro HUB_NORM_CORR_CNT_EN adds a saturating count of corrected beats on corr_cnt.
module hub_norm_pipe
  import hub_fp_pkg::*;
#(
  parameter int M  = M_W,
  parameter int E  = E_W,
  parameter int SW = $clog2(M + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M:0]    in_mant,
  input  logic [SW-1:0] in_shift,
  input  logic [E-1:0]  in_exp,
  input  logic          in_sign,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_mant,
  output logic [E-1:0]  out_exp,
  output logic          out_sign,
  output logic          out_zero,
  output logic          out_uflow
`ifdef HUB_NORM_CORR_CNT_EN
  ,
  output logic [15:0]   corr_cnt
`endif
);

  // Payload widths come from the package; M/E/SW must stay at the package values.
  s1_payload_t   s1;
  logic          s1_valid;
  logic          s2_valid;
  logic          s2_ready;
  logic          accept;
  logic [SW-1:0] sh_c;
  logic [M:0]    m_shift;

  assign s2_ready  = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  assign sh_c = clamp_shift(in_shift);

  hub_lshift #(.W(M + 1), .SW(SW)) u_lshift (
    .data   (in_mant),
    .sh     (sh_c),
    .result (m_shift)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1 <= '{mant: m_shift, sh: sh_c, exp: in_exp, sign: in_sign, zero: (in_mant == '0)};
      end
    end
  end

  logic          corr;
  logic [M-1:0]  mn;
  logic [SW:0]   tot;
  logic [E:0]    e;
  logic          uflow;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    corr  = 1'b0;
    mn    = '0;
    tot   = '0;
    e     = '0;
    uflow = 1'b0;
    corr  = !s1.mant[M] && !s1.zero;
    mn    = corr ? {s1.mant[M-2:0], 1'b0} : s1.mant[M-1:0];
    tot   = {1'b0, s1.sh} + {{SW{1'b0}}, corr};
    e     = {1'b0, s1.exp} - (E+1)'(tot);
    // Borrow in the top bit or an exact zero both mean in_exp <= tot.
    uflow = !s1.zero && (e[E] || (e == '0));
  end

`ifdef HUB_NORM_CORR_CNT_EN
  logic s2_corr;
`endif

  // NOTE: output payload registers are reset too, because the outputs must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      out_mant  <= '0;
      out_exp   <= '0;
      out_sign  <= 1'b0;
      out_zero  <= 1'b0;
      out_uflow <= 1'b0;
`ifdef HUB_NORM_CORR_CNT_EN
      s2_corr   <= 1'b0;
`endif
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_sign  <= s1.sign;
        out_zero  <= s1.zero || uflow;
        out_uflow <= uflow;
        out_mant  <= (s1.zero || uflow) ? '0 : mn;
        out_exp   <= (s1.zero || uflow) ? '0 : e[E-1:0];
`ifdef HUB_NORM_CORR_CNT_EN
        s2_corr   <= corr;
`endif
      end
    end
  end

`ifdef HUB_NORM_CORR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt <= '0;
    end else if (s2_valid && out_ready && s2_corr && (corr_cnt != 16'hFFFF)) begin
      corr_cnt <= corr_cnt + 16'd1;
    end
  end
`endif

endmodule
